// File: rtl/mem_req_arbiter.sv
// Two-requester round-robin arbiter that runs one single-beat AXI-Lite
// transaction at a time. Define ARB_STATS_EN to add saturating grant/error counters.
module mem_req_arbiter #(
    parameter int unsigned ADDR_WDTH = 4,
    parameter int unsigned DATA_WDTH = 32,
    parameter int unsigned RESP_WDTH = 1
`ifdef ARB_STATS_EN
    ,
    localparam int unsigned CNT_WDTH = 16
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0]             req_write,
    input  logic [2*ADDR_WDTH-1:0] req_addr,
    input  logic [2*DATA_WDTH-1:0] req_wdata,
    output logic [1:0]             rsp_valid,
    output logic [DATA_WDTH-1:0]   rsp_data,
    output logic [RESP_WDTH-1:0]   rsp_resp,
    output logic                   ar_valid,
    input  logic                   ar_ready,
    output logic [ADDR_WDTH-1:0]   ar_address,
    input  logic                   r_valid,
    output logic                   r_ready,
    input  logic [DATA_WDTH-1:0]   r_data,
    input  logic [RESP_WDTH-1:0]   r_resp,
    output logic                   aw_valid,
    input  logic                   aw_ready,
    output logic [ADDR_WDTH-1:0]   aw_address,
    output logic                   w_valid,
    input  logic                   w_ready,
    output logic [DATA_WDTH-1:0]   w_data,
    input  logic                   b_valid,
    output logic                   b_ready,
    input  logic [RESP_WDTH-1:0]   b_resp,
    output logic                   busy
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_WDTH-1:0]    grant_cnt0,
    output logic [CNT_WDTH-1:0]    grant_cnt1,
    output logic [CNT_WDTH-1:0]    err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_AR = 3'd1,
        WAIT_R   = 3'd2,
        ISSUE_AW = 3'd3,
        ISSUE_W  = 3'd4,
        WAIT_B   = 3'd5,
        RESPOND  = 3'd6
    } state_e;

    state_e                 state_q;
    logic                   last_grant_q;
    logic                   gnt_q;
    logic [ADDR_WDTH-1:0]   cmd_addr_q;
    logic [DATA_WDTH-1:0]   cmd_wdata_q;
    logic                   ar_valid_q;
    logic                   r_ready_q;
    logic                   aw_valid_q;
    logic                   w_valid_q;
    logic                   b_ready_q;
    logic                   busy_q;
    logic [1:0]             rsp_valid_q;
    logic [DATA_WDTH-1:0]   rsp_data_q;
    logic [RESP_WDTH-1:0]   rsp_resp_q;

    logic                   accept_c;
    logic                   gnt_c;
    logic                   sel_write_c;
    logic [ADDR_WDTH-1:0]   sel_addr_c;
    logic [DATA_WDTH-1:0]   sel_wdata_c;

    // Ties go to the requester that was not served last.
    always_comb begin
        accept_c    = (state_q == IDLE) && (req_valid != 2'b00);
        gnt_c       = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        sel_write_c = req_write[gnt_c];
        sel_addr_c  = gnt_c ? req_addr[2*ADDR_WDTH-1:ADDR_WDTH] : req_addr[ADDR_WDTH-1:0];
        sel_wdata_c = gnt_c ? req_wdata[2*DATA_WDTH-1:DATA_WDTH] : req_wdata[DATA_WDTH-1:0];
        req_ready   = accept_c ? {gnt_c, ~gnt_c} : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_data_q   <= '0;
            rsp_resp_q   <= '0;
        end else begin
            rsp_valid_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        cmd_addr_q   <= sel_addr_c;
                        cmd_wdata_q  <= sel_wdata_c;
                        gnt_q        <= gnt_c;
                        last_grant_q <= gnt_c;
                        busy_q       <= 1'b1;
                        if (sel_write_c) begin
                            aw_valid_q <= 1'b1;
                            state_q    <= ISSUE_AW;
                        end else begin
                            ar_valid_q <= 1'b1;
                            state_q    <= ISSUE_AR;
                        end
                    end
                end
                ISSUE_AR: begin
                    if (ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        state_q    <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (r_valid) begin
                        r_ready_q   <= 1'b0;
                        rsp_data_q  <= r_data;
                        rsp_resp_q  <= r_resp;
                        rsp_valid_q <= {gnt_q, ~gnt_q};
                        state_q     <= RESPOND;
                    end
                end
                // Write address is always handed over before the data beat.
                ISSUE_AW: begin
                    if (aw_ready) begin
                        aw_valid_q <= 1'b0;
                        w_valid_q  <= 1'b1;
                        state_q    <= ISSUE_W;
                    end
                end
                ISSUE_W: begin
                    if (w_ready) begin
                        w_valid_q <= 1'b0;
                        b_ready_q <= 1'b1;
                        state_q   <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_valid) begin
                        b_ready_q   <= 1'b0;
                        rsp_data_q  <= '0;
                        rsp_resp_q  <= b_resp;
                        rsp_valid_q <= {gnt_q, ~gnt_q};
                        state_q     <= RESPOND;
                    end
                end
                RESPOND: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ar_valid_q <= 1'b0;
                    r_ready_q  <= 1'b0;
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b0;
                    b_ready_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign ar_valid   = ar_valid_q;
    assign ar_address = cmd_addr_q;
    assign r_ready    = r_ready_q;
    assign aw_valid   = aw_valid_q;
    assign aw_address = cmd_addr_q;
    assign w_valid    = w_valid_q;
    assign w_data     = cmd_wdata_q;
    assign b_ready    = b_ready_q;
    assign busy       = busy_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_resp   = rsp_resp_q;

`ifdef ARB_STATS_EN
    // Errors are counted in the cycle the response is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            err_cnt    <= '0;
        end else begin
            if (accept_c && !gnt_c && (grant_cnt0 != '1)) begin
                grant_cnt0 <= grant_cnt0 + CNT_WDTH'(1);
            end
            if (accept_c && gnt_c && (grant_cnt1 != '1)) begin
                grant_cnt1 <= grant_cnt1 + CNT_WDTH'(1);
            end
            if ((state_q == RESPOND) && (rsp_resp_q == '0) && (err_cnt != '1)) begin
                err_cnt <= err_cnt + CNT_WDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter with a behavioural AXI-Lite memory.
module tb_mem_req_arbiter;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      req_valid = 2'b00;
    logic [1:0]      req_ready;
    logic [1:0]      req_write = 2'b00;
    logic [2*AW-1:0] req_addr = '0;
    logic [2*DW-1:0] req_wdata = '0;
    logic [1:0]      rsp_valid;
    logic [DW-1:0]   rsp_data;
    logic [RW-1:0]   rsp_resp;
    logic            ar_valid, ar_ready, r_valid, r_ready;
    logic [AW-1:0]   ar_address, aw_address;
    logic [DW-1:0]   r_data, w_data;
    logic [RW-1:0]   r_resp, b_resp;
    logic            aw_valid, aw_ready, w_valid, w_ready, b_valid, b_ready, busy;
`ifdef ARB_STATS_EN
    logic [15:0]     grant_cnt0, grant_cnt1, err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_req_arbiter #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_resp(rsp_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_address(aw_address),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
        .busy(busy)
`ifdef ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .err_cnt(err_cnt)
`endif
    );

    // ---------------- memory slave model (reset with the same rst_n) ----------------
    logic [DW-1:0] mem [16];
    int            aw_delay = 0;
    int            b_delay = 0;
    bit            always_error = 1'b0;
    int            aw_wait;
    logic          aw_seen;
    logic [AW-1:0] aw_addr_lat;
    int            b_cnt;
    logic          b_pend;

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 3) ? 32'hDEADBEEF : (32'hC0DE0000 | 32'(i));
    endfunction

    assign ar_ready = ar_valid;
    assign aw_ready = aw_valid && (aw_wait >= aw_delay);
    assign w_ready  = w_valid && aw_seen;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
            r_valid <= 1'b0; r_data <= '0; r_resp <= '0;
            b_valid <= 1'b0; b_resp <= '0;
            aw_wait <= 0; aw_seen <= 1'b0; aw_addr_lat <= '0;
            b_cnt <= 0; b_pend <= 1'b0;
        end else begin
            if (ar_valid && ar_ready) begin
                r_valid <= 1'b1;
                r_data  <= mem[ar_address];
                r_resp  <= RW'(!always_error);
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
            if (aw_valid && aw_ready) begin
                aw_seen     <= 1'b1;
                aw_addr_lat <= aw_address;
                aw_wait     <= 0;
            end else if (aw_valid) begin
                aw_wait <= aw_wait + 1;
            end else begin
                aw_wait <= 0;
            end
            if (w_valid && w_ready) begin
                aw_seen          <= 1'b0;
                mem[aw_addr_lat] <= w_data;
                if (b_delay == 0) begin
                    b_valid <= 1'b1;
                    b_resp  <= RW'(!always_error);
                end else begin
                    b_pend <= 1'b1;
                    b_cnt  <= 1;
                end
            end
            if (b_pend) begin
                if (b_cnt >= b_delay) begin
                    b_valid <= 1'b1;
                    b_resp  <= RW'(!always_error);
                    b_pend  <= 1'b0;
                end else begin
                    b_cnt <= b_cnt + 1;
                end
            end
            if (b_valid && b_ready) b_valid <= 1'b0;
        end
    end

    // ---------------- protocol monitor: no valid drop before ready, AW before W ----------------
    int   drop_err = 0;
    int   order_err = 0;
    logic ar_pend, aw_pend, w_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_pend <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
        end else begin
            if ((ar_pend && !ar_valid) || (aw_pend && !aw_valid) || (w_pend && !w_valid))
                drop_err <= drop_err + 1;
            if (w_valid && (aw_valid || !aw_seen))
                order_err <= order_err + 1;
            ar_pend <= ar_valid && !ar_ready;
            aw_pend <= aw_valid && !aw_ready;
            w_pend  <= w_valid && !w_ready;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timeout", nm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_accept(output int g);
        g = -1;
        for (int n = 0; n < 20; n++) begin
            #1;
            if (req_ready != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                return;
            end
            @(negedge clk);
        end
        tmo("accept");
    endtask

    task automatic wait_rsp(output logic [1:0] v, output logic [DW-1:0] d,
                            output logic [RW-1:0] r, output int n);
        n = -1; v = 2'b00; d = '0; r = '0;
        for (int k = 0; k < 60; k++) begin
            if (rsp_valid != 2'b00) begin
                v = rsp_valid; d = rsp_data; r = rsp_resp; n = k;
                return;
            end
            @(negedge clk);
        end
        tmo("response");
    endtask

    typedef struct {
        logic [1:0]    v;
        logic [1:0]    wr;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int            exp_g;
        logic [DW-1:0] exp_data;
        logic [RW-1:0] exp_resp;
        int            exp_lat;
    } vec_t;

    // Issue one command, scramble the requester fields after accept, check the outcome.
    task automatic run_txn(input vec_t t, input string nm);
        int g, n;
        logic [1:0] v;
        logic [DW-1:0] d;
        logic [RW-1:0] r;
        @(negedge clk);
        req_valid = t.v; req_write = t.wr;
        req_addr = {t.a1, t.a0}; req_wdata = {t.d1, t.d0};
        wait_accept(g);
        @(negedge clk);
        req_valid = 2'b00;
        req_write = 2'($urandom);
        req_addr  = 8'($urandom);
        req_wdata = {$urandom, $urandom};
        if (g < 0) return;
        wait_rsp(v, d, r, n);
        if (n < 0) return;
        chk({nm, "_grant"}, 64'(g), 64'(t.exp_g));
        chk({nm, "_rsp_valid"}, 64'(v), (t.exp_g == 1) ? 64'd2 : 64'd1);
        chk({nm, "_rsp_data"}, 64'(d), 64'(t.exp_data));
        chk({nm, "_rsp_resp"}, 64'(r), 64'(t.exp_resp));
        chk({nm, "_latency"}, 64'(n + 1), 64'(t.exp_lat));
        @(negedge clk);
        chk({nm, "_pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    // Random traffic against a cycle-count model of the arbiter (memory answers with no delay).
    task automatic random_phase(input int ncyc);
        logic [DW-1:0] mm [16];
        int last_g = 1, acc_cyc = -1, rsp_cyc = -1, pend_g = 0, g, a;
        int n0 = 0, n1 = 0;
        logic [DW-1:0] pend_data = '0, cur_data = '0;
        logic [RW-1:0] cur_resp = '0;
        logic [1:0] exp_ready;
        for (int i = 0; i < 16; i++) mm[i] = init_word(i);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            if (cyc == rsp_cyc) begin
                cur_data = pend_data;
                cur_resp = 1'b1;
                chk("rnd_rsp_valid", 64'(rsp_valid), (pend_g == 1) ? 64'd2 : 64'd1);
            end else begin
                chk("rnd_rsp_idle", 64'(rsp_valid), 64'd0);
            end
            chk("rnd_rsp_data", 64'(rsp_data), 64'(cur_data));
            chk("rnd_rsp_resp", 64'(rsp_resp), 64'(cur_resp));
            chk("rnd_busy", 64'(busy), 64'((cyc > acc_cyc) && (cyc <= rsp_cyc)));
            req_valid = 2'($urandom);
            req_write = 2'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = {$urandom, $urandom};
            #1;
            exp_ready = 2'b00;
            if ((cyc > rsp_cyc) && (req_valid != 2'b00)) begin
                g = (req_valid == 2'b11) ? (1 - last_g) : (req_valid[1] ? 1 : 0);
                exp_ready = (g == 1) ? 2'b10 : 2'b01;
                a = (g == 1) ? int'(req_addr[2*AW-1:AW]) : int'(req_addr[AW-1:0]);
                if (req_write[g]) begin
                    mm[a] = (g == 1) ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                    pend_data = '0;
                    rsp_cyc = cyc + 4;
                end else begin
                    pend_data = mm[a];
                    rsp_cyc = cyc + 3;
                end
                if (g == 1) n1++; else n0++;
                pend_g = g; last_g = g; acc_cyc = cyc;
            end
            chk("rnd_ready", 64'(req_ready), 64'(exp_ready));
        end
        @(negedge clk);
        req_valid = 2'b00;
`ifdef ARB_STATS_EN
        chk("rnd_grant_cnt0", 64'(grant_cnt0), 64'(n0));
        chk("rnd_grant_cnt1", 64'(grant_cnt1), 64'(n1));
        chk("rnd_err_cnt", 64'(err_cnt), 64'd0);
`else
        if (n0 + n1 == 0) tmo("rnd_no_grants");
`endif
    endtask

    // ---------------- main sequence ----------------
    vec_t vecs[9];
    int   g, n, ng, both_cnt, stall;
    int   gseq[4];
    int   gcyc[4];
    logic [1:0]    rv;
    logic [DW-1:0] rd;
    logic [RW-1:0] rr;

    initial begin
        vecs[0] = '{2'b01, 2'b00, 4'h3, 4'h0, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b1, 3};
        vecs[1] = '{2'b10, 2'b10, 4'h0, 4'hA, 32'h0, 32'h12345678, 1, 32'h0, 1'b1, 4};
        vecs[2] = '{2'b10, 2'b00, 4'h0, 4'hA, 32'h0, 32'h0, 1, 32'h12345678, 1'b1, 3};
        vecs[3] = '{2'b11, 2'b00, 4'h3, 4'hA, 32'h0, 32'h0, 0, 32'hDEADBEEF, 1'b1, 3};
        vecs[4] = '{2'b11, 2'b00, 4'h3, 4'hA, 32'h0, 32'h0, 1, 32'h12345678, 1'b1, 3};
        vecs[5] = '{2'b01, 2'b01, 4'h5, 4'h0, 32'h00005555, 32'h0, 0, 32'h0, 1'b1, 4};
        vecs[6] = '{2'b11, 2'b00, 4'h5, 4'h3, 32'h0, 32'h0, 1, 32'hDEADBEEF, 1'b1, 3};
        vecs[7] = '{2'b11, 2'b00, 4'h5, 4'h3, 32'h0, 32'h0, 0, 32'h00005555, 1'b1, 3};
        vecs[8] = '{2'b10, 2'b00, 4'h0, 4'h7, 32'h0, 32'h0, 1, 32'hC0DE0007, 1'b1, 3};

        // reset values
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_resp", 64'(rsp_resp), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_axi_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
        chk("rst_ar_address", 64'(ar_address), 64'd0);
`ifdef ARB_STATS_EN
        chk("rst_counters", 64'({grant_cnt0, grant_cnt1, err_cnt}), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // both requesters held valid: alternating grants, 4-cycle spacing for reads
        do_reset();
        @(negedge clk);
        req_valid = 2'b11; req_write = 2'b00; req_addr = {4'h2, 4'h1};
        ng = 0; both_cnt = 0;
        for (int k = 0; (k < 60) && (ng < 4); k++) begin
            #1;
            if (req_ready == 2'b11) both_cnt++;
            if (req_ready != 2'b00) begin
                gseq[ng] = req_ready[1] ? 1 : 0;
                gcyc[ng] = k;
                ng++;
            end
            @(negedge clk);
        end
        req_valid = 2'b00;
        chk("rr_never_both_ready", 64'(both_cnt), 64'd0);
        if (ng == 4) begin
            for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 64'(gseq[i]), 64'(i % 2));
            for (int i = 1; i < 4; i++) chk($sformatf("rr_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd4);
        end else begin
            tmo("rr_grants");
        end
        repeat (6) @(negedge clk);

        // AW backpressure: address held stable, no W until after AW handshake
        aw_delay = 5;
        req_valid = 2'b01; req_write = 2'b01; req_addr = {4'h0, 4'h9}; req_wdata = {32'h0, 32'h00000099};
        wait_accept(g);
        @(negedge clk);
        req_valid = 2'b00; req_addr = 8'hFF;
        stall = 0;
        for (int k = 0; k < 20; k++) begin
            if (aw_valid && aw_ready) break;
            if (aw_valid && (aw_address != 4'h9)) stall = 100;
            if (w_valid) stall = 200;
            if (aw_valid) stall++;
            @(negedge clk);
        end
        chk("bp_aw_stall_cycles", 64'(stall), 64'd5);
        @(negedge clk);
        chk("bp_w_after_aw", 64'(w_valid), 64'd1);
        wait_rsp(rv, rd, rr, n);
        chk("bp_write_resp", 64'(rr), 64'd1);
        aw_delay = 0;
        run_txn('{2'b01, 2'b00, 4'h9, 4'h0, 32'h0, 32'h0, 0, 32'h00000099, 1'b1, 3}, "bp_readback");

        // error response passes through
        do_reset();
        always_error = 1'b1;
        run_txn('{2'b01, 2'b00, 4'h2, 4'h0, 32'h0, 32'h0, 0, 32'hC0DE0002, 1'b0, 3}, "err_read");
        always_error = 1'b0;
`ifdef ARB_STATS_EN
        chk("err_cnt", 64'(err_cnt), 64'd1);
        chk("err_grant_cnt0", 64'(grant_cnt0), 64'd1);
        chk("err_grant_cnt1", 64'(grant_cnt1), 64'd0);
`endif

        // reset while waiting for the write response
        b_delay = 4;
        @(negedge clk);
        req_valid = 2'b10; req_write = 2'b10; req_addr = {4'h6, 4'h0}; req_wdata = {32'h66, 32'h0};
        wait_accept(g);
        @(negedge clk);
        req_valid = 2'b00;
        n = -1;
        for (int k = 0; k < 20; k++) begin
            if (b_ready) begin n = k; break; end
            @(negedge clk);
        end
        if (n < 0) tmo("mid_reset_wait_b");
        rst_n = 1'b0;
        #1;
        chk("mid_reset_busy", 64'(busy), 64'd0);
        chk("mid_reset_valids", 64'({ar_valid, aw_valid, w_valid, r_ready, b_ready}), 64'd0);
        chk("mid_reset_rsp", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("mid_reset_busy_next", 64'(busy), 64'd0);
        chk("mid_reset_rsp_next", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        b_delay = 0;
        run_txn('{2'b01, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 0, 32'hC0DE0000, 1'b1, 3}, "post_reset_read");

        do_reset();
        random_phase(400);
        repeat (6) @(negedge clk);

        chk("valid_held_until_ready", 64'(drop_err), 64'd0);
        chk("aw_before_w", 64'(order_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
